// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_VAL    = 4'd3;

  // Largest value representable in n BCD digits (10^n - 1).
  function automatic logic [31:0] ovf_limit(input int unsigned n);
    logic [31:0] p;
    p = 32'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 32'd10;
    return p - 32'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble correction cell: nibbles of 5 or more get 3 added before the shift.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = (digit_i >= ADD3_THRESH) ? digit_i + ADD3_VAL : digit_i;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock; feeds 7-segment digit drivers.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int          BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int          SH_W  = BCD_W + WIDTH;
  localparam int          CNT_W = $clog2(WIDTH + 1);
  localparam logic [31:0] LIMIT = ovf_limit(DIGITS);
  localparam logic [BCD_W-1:0] BCD_SAT = {DIGITS{4'h9}};

  state_t             state_q;
  logic [SH_W-1:0]    sh_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_pend_q;
  logic               busy_q;
  logic               done_q;
  logic               ovf_q;
  logic [BCD_W-1:0]   bcd_q;

  logic [SH_W-1:0]    sh_corr;
  logic [SH_W-1:0]    sh_d;

  assign sh_corr[WIDTH-1:0] = sh_q[WIDTH-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (sh_q[WIDTH + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .digit_o (sh_corr[WIDTH + BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  assign sh_d = {sh_corr[SH_W-2:0], 1'b0};

  // Result registers load on the final shift so they are already valid in the DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sh_q       <= {{BCD_W{1'b0}}, bin};
            cnt_q      <= CNT_W'(WIDTH);
            ovf_pend_q <= (32'(bin) > LIMIT);
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          sh_q  <= sh_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            ovf_q   <= ovf_pend_q;
            bcd_q   <= ovf_pend_q ? BCD_SAT : sh_d[SH_W-1 -: BCD_W];
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: 4-digit and 3-digit (overflow-capable) instances.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [9:0]  bin0 = '0, bin1 = '0;
  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  logic [15:0] bcd0;
  logic [11:0] bcd1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [15:0] held0 = '0;
  logic [11:0] held1 = '0;
  logic        heldo0 = 1'b0, heldo1 = 1'b0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(10), .DIGITS(4)) u0 (
    .clk(clk), .reset(reset), .start(start0), .bin(bin0),
    .busy(busy0), .done(done0), .ovf(ovf0), .bcd(bcd0)
  );

  bin2bcd_seq #(.WIDTH(10), .DIGITS(3)) u1 (
    .clk(clk), .reset(reset), .start(start1), .bin(bin1),
    .busy(busy1), .done(done1), .ovf(ovf1), .bcd(bcd1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits by division, saturating to all nines past 10^d-1.
  function automatic logic [16:0] model(input int unsigned v, input int unsigned d);
    int unsigned lim, p;
    logic [15:0] r;
    lim = 1;
    for (int unsigned i = 0; i < d; i++) lim = lim * 10;
    lim = lim - 1;
    r = '0;
    if (v > lim) begin
      for (int unsigned k = 0; k < d; k++) r[4*k +: 4] = 4'h9;
      return {1'b1, r};
    end
    p = 1;
    for (int unsigned k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return {1'b0, r};
  endfunction

  always @(negedge clk) begin
    logic [16:0] e;
    if (reset) begin
      held0 = '0; held1 = '0; heldo0 = 1'b0; heldo1 = 1'b0;
    end else begin
      if (done0) begin
        if (q0.size() == 0) chk("u0 spurious done", 32'(done0), 32'd0);
        else begin
          e = q0.pop_front();
          chk("u0 bcd", 32'(bcd0), 32'(e[15:0]));
          chk("u0 ovf", 32'(ovf0), 32'(e[16]));
        end
        held0 = bcd0; heldo0 = ovf0;
      end else begin
        chk("u0 bcd hold", 32'({ovf0, bcd0}), 32'({heldo0, held0}));
      end
      if (done1) begin
        if (q1.size() == 0) chk("u1 spurious done", 32'(done1), 32'd0);
        else begin
          e = q1.pop_front();
          chk("u1 bcd", 32'(bcd1), 32'(e[11:0]));
          chk("u1 ovf", 32'(ovf1), 32'(e[16]));
        end
        held1 = bcd1; heldo1 = ovf1;
      end else begin
        chk("u1 bcd hold", 32'({ovf1, bcd1}), 32'({heldo1, held1}));
      end
    end
  end

  task automatic drive(input int unsigned sel, input logic s, input logic [9:0] b);
    if (sel == 0) begin start0 = s; bin0 = b; end
    else begin start1 = s; bin1 = b; end
  endtask

  function automatic logic get_busy(input int unsigned sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction

  function automatic logic get_done(input int unsigned sel);
    return (sel == 0) ? done0 : done1;
  endfunction

  // One conversion from idle; optionally pokes start with another value while busy.
  task automatic convert(input int unsigned sel, input int unsigned v,
                         input bit poke, input logic [9:0] pokev);
    int unsigned n;
    logic seen;
    if (sel == 0) q0.push_back(model(v, 4));
    else q1.push_back(model(v, 3));
    @(negedge clk);
    drive(sel, 1'b1, 10'(v));
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) drive(sel, 1'b0, 10'($urandom_range(0, 1023)));
      if (poke && n == 4) drive(sel, 1'b1, pokev);
      if (poke && n == 5) drive(sel, 1'b0, pokev);
      chk("busy during conversion", 32'(get_busy(sel)), 32'd1);
      if (get_done(sel)) seen = 1'b1;
    end
    chk("done seen", 32'(seen), 32'd1);
    chk("latency", n, 32'd11);
    @(negedge clk);
    chk("busy low after done", 32'(get_busy(sel)), 32'd0);
    chk("done one cycle", 32'(get_done(sel)), 32'd0);
  endtask

  initial begin
    int unsigned t1, t2;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy0), 32'd0);
    chk("reset done", 32'(done0), 32'd0);
    chk("reset bcd", 32'(bcd0), 32'd0);
    chk("reset ovf", 32'(ovf0), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    convert(0, 987, 1'b0, '0);
    convert(0, 0, 1'b0, '0);
    convert(0, 1023, 1'b0, '0);
    convert(0, 9, 1'b0, '0);
    convert(0, 10, 1'b0, '0);
    convert(0, 321, 1'b1, 10'd5);

    // Start held high: second accept lands in the idle cycle right after done.
    q0.push_back(model(100, 4));
    q0.push_back(model(200, 4));
    @(negedge clk);
    start0 = 1'b1; bin0 = 10'd100;
    t1 = 0; t2 = 0;
    for (int t = 1; t <= 60 && t2 == 0; t++) begin
      @(negedge clk);
      if (t == 1) bin0 = 10'd200;
      if (done0) begin
        if (t1 == 0) t1 = t;
        else t2 = t;
      end
      if (t1 != 0 && t == int'(t1) + 2) start0 = 1'b0;
    end
    start0 = 1'b0;
    chk("b2b first latency", t1, 32'd11);
    chk("b2b gap", t2 - t1, 32'd12);
    repeat (15) @(negedge clk);

    convert(1, 1000, 1'b0, '0);
    convert(1, 999, 1'b0, '0);
    convert(1, 1023, 1'b0, '0);

    for (int i = 0; i < 60; i++) begin
      convert($urandom_range(0, 1), $urandom_range(0, 1023),
              1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    convert(0, 987, 1'b0, '0);
    @(negedge clk);
    start0 = 1'b1; bin0 = 10'd1023;
    @(negedge clk);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset busy", 32'(busy0), 32'd0);
    chk("midreset done", 32'(done0), 32'd0);
    chk("midreset bcd", 32'(bcd0), 32'd0);
    chk("midreset ovf", 32'(ovf0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);

    chk("u0 queue drained", q0.size(), 32'd0);
    chk("u1 queue drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
